// File: rtl/cal_op_dispatch.sv
// rtl/cal_op_dispatch.sv - dispatches one calculator op to the shared arithmetic units
// Holds the operands on the unit bus until the selected unit's done pulse, a timeout, or an illegal opcode produces the response.
module cal_op_dispatch #(
  parameter int NUM_UNITS = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [15:0]             cmd_a,
  input  logic [15:0]             cmd_b,
  output logic                    unit_start,
  output logic [3:0]              unit_dtype,
  output logic [15:0]             unit_m,
  output logic [15:0]             unit_q,
  input  logic [NUM_UNITS-1:0]    unit_done,
  input  logic [32*NUM_UNITS-1:0] unit_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [3:0] DTYPE_NONE = 4'hF;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [3:0]     dtype_nxt;
  logic [15:0]    m_nxt, q_nxt;
  logic [31:0]    data_nxt;
  logic           err_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic           sel_done;
  logic [31:0]    sel_result;
  logic           op_legal;

  assign op_legal   = ({28'd0, cmd_op} < 32'(NUM_UNITS));
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign unit_start = (state == LAUNCH);
  assign rsp_valid  = (state == RESP);

  // Only the unit addressed by the latched opcode is listened to.
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unit_dtype == 4'(i)) begin
        sel_done   = unit_done[i];
        sel_result = unit_result[32*i +: 32];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    dtype_nxt = unit_dtype;
    m_nxt     = unit_m;
    q_nxt     = unit_q;
    data_nxt  = rsp_data;
    err_nxt   = rsp_err;
    timer_nxt = timer;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          dtype_nxt = cmd_op;
          m_nxt     = cmd_a;
          q_nxt     = cmd_b;
          if (op_legal) begin
            state_nxt = LAUNCH;
          end else begin
            state_nxt = RESP;
            data_nxt  = '0;
            err_nxt   = 1'b1;
          end
        end
      end
      LAUNCH: begin
        timer_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        timer_nxt = timer + TW'(1);
        // Done takes priority over a coincident timeout.
        if (sel_done) begin
          data_nxt  = sel_result;
          err_nxt   = 1'b0;
          state_nxt = RESP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          data_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
          dtype_nxt = DTYPE_NONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      unit_dtype <= DTYPE_NONE;
      unit_m     <= '0;
      unit_q     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      timer      <= '0;
    end else begin
      state      <= state_nxt;
      unit_dtype <= dtype_nxt;
      unit_m     <= m_nxt;
      unit_q     <= q_nxt;
      rsp_data   <= data_nxt;
      rsp_err    <= err_nxt;
      timer      <= timer_nxt;
    end
  end

endmodule

// File: tb/tb_cal_op_dispatch.sv
// tb/tb_cal_op_dispatch.sv - directed bench for cal_op_dispatch with a mul_u unit model
// Unit 2 is a behavioural multiplier answering 18 cycles after start; other done bits are bench-driven.
module tb_cal_op_dispatch;

  localparam int NUM_UNITS = 5;
  localparam int TIMEOUT   = 64;

  logic                    clk = 1'b0;
  logic                    n_rst = 1'b0;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [3:0]              cmd_op;
  logic [15:0]             cmd_a;
  logic [15:0]             cmd_b;
  logic                    unit_start;
  logic [3:0]              unit_dtype;
  logic [15:0]             unit_m;
  logic [15:0]             unit_q;
  logic [NUM_UNITS-1:0]    unit_done;
  logic [32*NUM_UNITS-1:0] unit_result;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [31:0]             rsp_data;
  logic                    rsp_err;
  logic                    busy;

  logic                    mul_done;
  logic [31:0]             mul_res;
  logic [NUM_UNITS-1:0]    extra_done;
  int                      mul_cnt;
  int                      starts;
  int                      checks;
  int                      errors;

  cal_op_dispatch #(.NUM_UNITS(NUM_UNITS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .unit_start(unit_start), .unit_dtype(unit_dtype), .unit_m(unit_m), .unit_q(unit_q),
    .unit_done(unit_done), .unit_result(unit_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign unit_done   = extra_done | (NUM_UNITS'(mul_done) << 2);
  assign unit_result = {32'h4444_4444, 32'h3333_3333, mul_res, 32'h1111_1111, 32'h1000_0000};

  always @(negedge clk) if (unit_start) starts++;

  // Behavioural mul_u: done is high during the 18th cycle after the start cycle.
  initial begin
    mul_done = 1'b0;
    mul_res  = '0;
    mul_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!n_rst) begin
        mul_cnt  = 0;
        mul_done = 1'b0;
      end else if (mul_cnt > 0) begin
        mul_cnt--;
        if (mul_cnt == 0) begin
          mul_done = 1'b1;
          mul_res  = {16'd0, unit_m} * {16'd0, unit_q};
        end
      end else begin
        mul_done = 1'b0;
        if (unit_start && unit_dtype == 4'd2) mul_cnt = 18;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, input int pulse_at, output int n);
    n = 0;
    while (!rsp_valid && n < max) begin
      @(posedge clk);
      #1;
      n++;
      extra_done = (n == pulse_at) ? NUM_UNITS'(5'b00100) : '0;
    end
    extra_done = '0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int s0;
    int bad;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    rsp_ready  = 1'b1;
    extra_done = '0;
    starts     = 0;
    checks     = 0;
    errors     = 0;

    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_dtype", 32'(unit_dtype), 32'hF);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_no_start", 32'(starts), 32'd0);

    // mul_u 3*5
    s0 = starts;
    send_cmd(4'd2, 16'h0003, 16'h0005);
    check("mul_start", 32'(unit_start), 32'd1);
    check("mul_dtype", 32'(unit_dtype), 32'd2);
    check("mul_busy", 32'(busy), 32'd1);
    wait_rsp(100, 0, n);
    check("mul_latency", 32'(n), 32'd19);
    check("mul_data", rsp_data, 32'h0000_000F);
    check("mul_err", 32'(rsp_err), 32'd0);
    check("mul_one_start", 32'(starts - s0), 32'd1);
    handshake();
    check("mul_idle", 32'(busy), 32'd0);
    check("mul_dtype_idle", 32'(unit_dtype), 32'hF);

    // mul_u FFFF*FFFF with consumer stalled
    rsp_ready = 1'b0;
    send_cmd(4'd2, 16'hFFFF, 16'hFFFF);
    wait_rsp(100, 0, n);
    check("big_latency", 32'(n), 32'd19);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_data !== 32'hFFFE_0001 || rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
          unit_m !== 16'hFFFF || unit_dtype !== 4'd2) bad++;
      @(posedge clk);
      #1;
    end
    check("big_stall_stable", 32'(bad), 32'd0);
    check("big_data", rsp_data, 32'hFFFE_0001);
    handshake();
    check("big_valid_drop", 32'(rsp_valid), 32'd0);
    check("big_cmd_ready", 32'(cmd_ready), 32'd1);

    // illegal opcode
    s0 = starts;
    send_cmd(4'h7, 16'h1234, 16'h5678);
    check("ill_valid", 32'(rsp_valid), 32'd1);
    check("ill_err", 32'(rsp_err), 32'd1);
    check("ill_data", rsp_data, 32'd0);
    check("ill_no_start", 32'(starts - s0), 32'd0);
    handshake();
    check("ill_idle", 32'(busy), 32'd0);

    // timeout on ADD with a foreign done pulse on unit 2
    send_cmd(4'd0, 16'h0001, 16'h0002);
    wait_rsp(200, 3, n);
    check("to_latency", 32'(n), 32'(TIMEOUT + 1));
    check("to_err", 32'(rsp_err), 32'd1);
    check("to_data", rsp_data, 32'd0);
    handshake();

    // reset in the middle of a mul_u
    send_cmd(4'd2, 16'h0002, 16'h0003);
    repeat (5) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_valid", 32'(rsp_valid), 32'd0);
    check("mrst_dtype", 32'(unit_dtype), 32'hF);
    check("mrst_m", 32'(unit_m), 32'd0);
    check("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0) bad++;
    end
    check("mrst_no_stale", 32'(bad), 32'd0);
    send_cmd(4'd2, 16'h0007, 16'h0009);
    wait_rsp(100, 0, n);
    check("post_latency", 32'(n), 32'd19);
    check("post_data", rsp_data, 32'h0000_003F);
    check("post_err", 32'(rsp_err), 32'd0);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
